// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and per-axis timing derivation.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 10;

  typedef struct packed {
    int unsigned total;
    int unsigned sync_start;
    int unsigned sync_end;
  } axis_timing_t;

  function automatic axis_timing_t axis_timing(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    axis_timing_t t;
    t.total      = active + fp + sync + bp;
    t.sync_start = active + fp;
    t.sync_end   = active + fp + sync - 1;
    return t;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered wrap/sync flags
// decoded from the next count so they always match the count shown.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter logic        POL    = 1'b0,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic          clk_25MHz,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active_c
);

  localparam axis_timing_t T = axis_timing(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(T.total - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(T.sync_start);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(T.sync_end);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_field
    $error("vga_axis_counter: every timing field must be >= 1");
  end
  if ((64'd1 << CW) < 64'(T.total)) begin : g_cw_narrow
    $error("vga_axis_counter: CW too narrow for axis total");
  end

  logic [CW-1:0] count_nxt;
  logic          sync_nxt;

  always_comb begin
    count_nxt = count;
    if (step) count_nxt = (count == LAST) ? '0 : count + CW'(1);
  end

  assign sync_nxt = (count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST);
  // Next-position active window, consumed by the parent's registered video_on.
  assign active_c = (count_nxt < ACT_END);

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      wrap  <= 1'b1;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      wrap  <= (count_nxt == LAST);
      sync  <= sync_nxt ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axes, syncs,
// visible window and line/frame start strobes, all registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic          clk_25MHz,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic h_active_c;
  logic v_active_c;
  logic v_step_c;

  assign v_step_c = en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_SYNC_POL), .CW(CW)
  ) u_h_axis (
    .clk_25MHz(clk_25MHz),
    .rst_n    (rst_n),
    .step     (en),
    .count    (h_count),
    .wrap     (h_wrap),
    .sync     (hsync),
    .active_c (h_active_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_SYNC_POL), .CW(CW)
  ) u_v_axis (
    .clk_25MHz(clk_25MHz),
    .rst_n    (rst_n),
    .step     (v_step_c),
    .count    (v_count),
    .wrap     (v_wrap),
    .sync     (vsync),
    .active_c (v_active_c)
  );

  // Wrap flags mark the last position, so they predict a move to h=0 / (0,0).
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      video_on    <= h_active_c & v_active_c;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Replaces the free-running horizontal-only counter with one block that holds both the horizontal and vertical counters.
- Produces polarity-configurable hsync/vsync, a video_on window, per-pixel coordinates, and line/frame start strobes.
- Sits between the 25 MHz pixel clock domain and the pixel/colour generation logic.
- Supports a clock-enable stall, so the raster can also be driven from a faster clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low)
- CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk_25MHz  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  pixel advance enable; when low, all state holds
- h_count  out  CW  current horizontal position, 0..H_TOTAL-1
- v_count  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- video_on  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_start  out  1  high while h_count == 0
- frame_start  out  1  high while h_count == 0 and v_count == 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Every timing field must be >= 1. Elaboration fails otherwise, or if CW is too narrow.
- Reset (async assert, sync release): h_count = H_TOTAL-1, v_count = V_TOTAL-1. This is the last blanking pixel of a frame.
  - video_on = 0, line_start = 0, frame_start = 0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL (deasserted).
- All outputs are registers. Each is computed from the next count value, so it always describes the position currently shown on h_count/v_count. Zero decode latency, no combinational output paths.
- Enabled edge (en = 1):
  - h_count increments. At H_TOTAL-1 it wraps to 0; the counter never holds the value H_TOTAL.
  - v_count increments only when h_count wraps. At V_TOTAL-1 with h wrapping, it wraps to 0.
- First enabled edge after reset moves to (0,0) with frame_start = line_start = video_on = 1.
- hsync is asserted for H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1.
- vsync is asserted for V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1.
  - vsync changes only together with a v_count change, i.e. aligned with h_count = 0.
- Stall (en = 0): counts and every output hold their value, including line_start/frame_start, which stay high if already high. Consumers qualify the strobes with en.
- Reset mid-frame returns immediately to the reset state. The next enabled edge starts a fresh frame at (0,0).
- Frame period = H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - a helper function computing TOTAL and sync start/end from (active, fp, sync, bp).
- Natural sub-module: vga_axis_counter.
  - Parameters: ACTIVE, FP, SYNC, BP, POL, CW.
  - Inputs: step. Outputs: count, wrap, sync, active.
  - Instantiated twice: horizontal with step = en; vertical with step = en & h_wrap.

Test Plan:
- Release reset, en = 1 constantly. Required: after 1 edge, (h,v) = (0,0), frame_start = 1. After 800 edges, (0,1) with line_start = 1 and frame_start = 0.
- Horizontal sync, defaults: hsync = 0 exactly for h = 656..751 (96 cycles), 1 elsewhere. video_on = 1 for h = 0..639 on line 0 and 0 for h = 640..799.
- Vertical sync, defaults: vsync = 0 for v = 490..491 (1600 cycles), 1 otherwise. video_on = 0 for all of lines 480..524. Next frame_start arrives exactly 420000 edges after the previous one.
- Small config H = 4/1/2/1, V = 3/1/1/1, POL = 1: H_TOTAL = 8, V_TOTAL = 6. hsync = 1 at h = 5..6, vsync = 1 at v = 4. Wraps to (0,0) after 48 edges.
- Toggle en in a 1-on / 2-off pattern mid-line. Required: counts advance only on en = 1. All outputs are held during en = 0. The frame takes 3x the cycles with the same sequence of positions.
- Assert rst_n low at (h,v) = (700,300), asynchronously between edges. Required: outputs immediately take reset values (h = 799, v = 524, syncs high, video_on = 0). After release, the first enabled edge gives (0,0) with frame_start = 1.
